// File: rtl/cpu_acumulador_param_if.sv
// Input/output handshake bundle of the accumulator CPU core.
// The master modport is the core side; the slave modport is the producer/consumer side.
interface cpu_acumulador_param_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] entrada;
  logic             entrada_valid;
  logic             entrada_ready;
  logic [WIDTH-1:0] saida;
  logic             saida_valid;
  logic             saida_ready;

  modport master (
    input  entrada, entrada_valid, saida_ready,
    output entrada_ready, saida, saida_valid
  );

  modport slave (
    output entrada, entrada_valid, saida_ready,
    input  entrada_ready, saida, saida_valid
  );
endinterface

// File: rtl/cpu_acumulador_param.sv
// Parametrised accumulator CPU: X operand, Y accumulator, Z output register,
// fetch/decode/execute controller with valid/ready input and output ports.
module cpu_acumulador_param #(
  parameter int WIDTH  = 5,
  parameter int ADDR_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  output logic [ADDR_W-1:0]   pc,
  input  logic [WIDTH+3:0]    instr,
  cpu_acumulador_param_if.master io,
  output logic [WIDTH-1:0]    acumulador,
  output logic [WIDTH-1:0]    reg_x,
  output logic                carry,
  output logic                zero,
  output logic [2:0]          estado,
  output logic                halted
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FETCH    = 3'd1;
  localparam logic [2:0] DECODE   = 3'd2;
  localparam logic [2:0] EXEC     = 3'd3;
  localparam logic [2:0] WAIT_IN  = 3'd4;
  localparam logic [2:0] WAIT_OUT = 3'd5;
  localparam logic [2:0] HALT     = 3'd6;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_IN   = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_MOVY = 4'hB;
  localparam logic [3:0] OP_OUT  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_JZ   = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  logic [2:0]        state;
  logic [WIDTH+3:0]  ir;
  logic [WIDTH-1:0]  x, y, z;
  logic              saida_valid_q;

  logic [3:0]        op;
  logic [WIDTH-1:0]  imm;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic [WIDTH:0]    sum, diff;

  logic [WIDTH-1:0]  alu_y;
  logic              alu_c;
  logic              alu_we;

  assign op     = ir[WIDTH+3:WIDTH];
  assign imm    = ir[WIDTH-1:0];
  assign pc_inc = pc + ADDR_W'(1);
  assign target = imm[ADDR_W-1:0];
  assign sum    = {1'b0, y} + {1'b0, x};
  // The extra top bit of the widened difference is the borrow (Y < X).
  assign diff   = {1'b0, y} - {1'b0, x};

  always_comb begin
    alu_y  = y;
    alu_c  = carry;
    alu_we = 1'b0;
    case (op)
      OP_ADD:  begin alu_y = sum[WIDTH-1:0];  alu_c = sum[WIDTH];  alu_we = 1'b1; end
      OP_SUB:  begin alu_y = diff[WIDTH-1:0]; alu_c = diff[WIDTH]; alu_we = 1'b1; end
      OP_AND:  begin alu_y = y & x;           alu_we = 1'b1; end
      OP_OR:   begin alu_y = y | x;           alu_we = 1'b1; end
      OP_XOR:  begin alu_y = y ^ x;           alu_we = 1'b1; end
      OP_NOT:  begin alu_y = ~y;              alu_we = 1'b1; end
      OP_SHL:  begin alu_y = y << 1; alu_c = y[WIDTH-1]; alu_we = 1'b1; end
      OP_SHR:  begin alu_y = y >> 1; alu_c = y[0];       alu_we = 1'b1; end
      OP_MOVY: begin alu_y = x;               alu_we = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pc            <= '0;
      ir            <= '0;
      x             <= '0;
      y             <= '0;
      z             <= '0;
      carry         <= 1'b0;
      zero          <= 1'b0;
      saida_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (run) state <= FETCH;
        FETCH: state <= DECODE;
        DECODE: begin
          ir    <= instr;
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          pc    <= pc_inc;
          if (alu_we) begin
            y     <= alu_y;
            carry <= alu_c;
            zero  <= (alu_y == '0);
          end
          // Waiting and halting opcodes hold pc; the wait states advance it on completion.
          case (op)
            OP_LDI: x <= imm;
            OP_IN: begin
              state <= WAIT_IN;
              pc    <= pc;
            end
            OP_OUT: begin
              z             <= y;
              saida_valid_q <= 1'b1;
              state         <= WAIT_OUT;
              pc            <= pc;
            end
            OP_JMP: pc <= target;
            OP_JZ:  if (zero) pc <= target;
            OP_HLT: begin
              state <= HALT;
              pc    <= pc;
            end
            default: ;
          endcase
        end
        WAIT_IN: if (io.entrada_valid) begin
          x     <= io.entrada;
          pc    <= pc_inc;
          state <= FETCH;
        end
        WAIT_OUT: if (io.saida_ready) begin
          saida_valid_q <= 1'b0;
          pc            <= pc_inc;
          state         <= FETCH;
        end
        HALT: if (run) begin
          pc    <= '0;
          state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.entrada_ready = (state == WAIT_IN);
  assign io.saida         = z;
  assign io.saida_valid   = saida_valid_q;
  assign acumulador       = y;
  assign reg_x            = x;
  assign estado           = state;
  assign halted           = (state == HALT);

endmodule

// File: tb/tb_cpu_acumulador_param.sv
// Bench for cpu_acumulador_param: directed programs plus random programs,
// checked per instruction against an instruction-level reference model.
module tb_cpu_acumulador_param;
  localparam int W  = 5;
  localparam int AW = 4;
  localparam int M  = 32;
  localparam int D  = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          run   = 1'b0;
  logic [AW-1:0] pc;
  logic [W+3:0]  instr;
  logic [W-1:0]  acumulador, reg_x;
  logic          carry, zero, halted;
  logic [2:0]    estado;
  logic [W+3:0]  prog [D];

  int vectors     = 0;
  int miscompares = 0;

  int m_pc, m_x, m_y, m_z, m_c, m_zf;
  bit m_halt;

  cpu_acumulador_param_if #(.WIDTH(W)) io ();

  cpu_acumulador_param #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .pc         (pc),
    .instr      (instr),
    .io         (io),
    .acumulador (acumulador),
    .reg_x      (reg_x),
    .carry      (carry),
    .zero       (zero),
    .estado     (estado),
    .halted     (halted)
  );

  assign instr = prog[pc];
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ins(input int op, input int imm);
    ins = {op[3:0], imm[4:0]};
  endfunction

  task automatic model_clear();
    m_pc = 0; m_x = 0; m_y = 0; m_z = 0; m_c = 0; m_zf = 0; m_halt = 0;
  endtask

  task automatic load_nops();
    for (int i = 0; i < D; i++) prog[i] = ins(0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0;
    io.entrada = '0; io.entrada_valid = 1'b0; io.saida_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    chk("rst_pc", pc, 0);
    chk("rst_estado", estado, 0);
    chk("rst_x", reg_x, 0);
    chk("rst_y", acumulador, 0);
    chk("rst_z", io.saida, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 0);
    chk("rst_saida_valid", io.saida_valid, 0);
    chk("rst_entrada_ready", io.entrada_ready, 0);
    chk("rst_halted", halted, 0);
    @(negedge clock);
    chk("idle_hold", estado, 0);
  endtask

  // Leave IDLE or HALT with a one-cycle run pulse.
  task automatic restart();
    bit from_halt;
    from_halt = m_halt;
    if (from_halt) begin
      repeat (2) @(negedge clock);
      chk("halt_frozen_state", estado, 6);
      chk("halt_frozen_pc", pc, m_pc);
    end
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
    if (from_halt) m_pc = 0;
    m_halt = 0;
    chk("restart_state", estado, 1);
    chk("restart_pc", pc, m_pc);
    chk("restart_y", acumulador, m_y);
  endtask

  // Execute one instruction starting at a FETCH cycle; dly extra wait cycles for IN/OUT.
  task automatic step(input int dly, input int din);
    logic [8:0] w;
    int op, imm, total, npc, s;
    bit is_wait;
    w   = prog[m_pc];
    op  = int'(w[8:5]);
    imm = int'(w[4:0]);
    chk("pc", pc, m_pc);
    chk("x", reg_x, m_x);
    chk("y", acumulador, m_y);
    chk("z", io.saida, m_z);
    chk("carry", carry, m_c);
    chk("zero", zero, m_zf);
    chk("estado_fetch", estado, 1);
    is_wait = (op == 2) || (op == 12);
    total   = is_wait ? 4 + dly : 3;
    for (int c = 1; c <= total; c++) begin
      run = 1'($urandom_range(0, 1));
      if (c <= 3) begin
        io.entrada       = W'($urandom_range(0, M - 1));
        io.entrada_valid = 1'($urandom_range(0, 1));
        io.saida_ready   = 1'($urandom_range(0, 1));
      end else begin
        io.entrada       = W'(din);
        io.entrada_valid = (op == 2) && (c == total);
        io.saida_ready   = (op == 12) && (c == total);
      end
      @(negedge clock);
      if (c == 1) chk("estado_decode", estado, 2);
      if (c == 2) chk("estado_exec", estado, 3);
      if (is_wait && c >= 3 && c < total) begin
        chk("wait_state", estado, (op == 2) ? 4 : 5);
        chk("wait_pc", pc, m_pc);
        chk("entrada_ready", io.entrada_ready, op == 2);
        chk("wait_saida_valid", io.saida_valid, op == 12);
        if (op == 12) chk("wait_saida", io.saida, m_y);
      end
    end
    run = 1'b0; io.entrada_valid = 1'b0; io.saida_ready = 1'b0;

    npc = (m_pc + 1) % D;
    case (op)
      1:  m_x = imm;
      2:  m_x = din;
      3:  begin s = m_y + m_x; m_c = (s >= M); m_y = s % M; end
      4:  begin m_c = (m_y < m_x); m_y = (m_y - m_x + M) % M; end
      5:  m_y = m_y & m_x;
      6:  m_y = m_y | m_x;
      7:  m_y = m_y ^ m_x;
      8:  m_y = M - 1 - m_y;
      9:  begin m_c = (m_y >= M / 2); m_y = (m_y * 2) % M; end
      10: begin m_c = m_y % 2; m_y = m_y / 2; end
      11: m_y = m_x;
      12: m_z = m_y;
      13: npc = imm % D;
      14: if (m_zf != 0) npc = imm % D;
      15: begin npc = m_pc; m_halt = 1; end
      default: ;
    endcase
    if (op >= 3 && op <= 11) m_zf = (m_y == 0);
    m_pc = npc;
    chk("next_state", estado, m_halt ? 6 : 1);
    chk("halted", halted, m_halt);
    chk("saida_valid_after", io.saida_valid, 0);
  endtask

  task automatic advance(input int dly, input int din);
    if (m_halt) restart();
    else step(dly, din);
  endtask

  initial begin
    io.entrada = '0; io.entrada_valid = 1'b0; io.saida_ready = 1'b0;
    load_nops();

    // LDI 7; MOVY; LDI 3; ADD; OUT; HLT
    prog[0] = ins(1, 7); prog[1] = ins(11, 0); prog[2] = ins(1, 3);
    prog[3] = ins(3, 0); prog[4] = ins(12, 0); prog[5] = ins(15, 0);
    do_reset(); restart();
    repeat (4) step(0, 0);
    step(0, 0);
    chk("plan_saida_10", io.saida, 10);
    chk("plan_carry_0", carry, 0);
    chk("plan_zero_0", zero, 0);
    step(0, 0);

    // ADD wrap, SUB borrow, SHL carry
    load_nops();
    prog[0] = ins(1, 31); prog[1] = ins(11, 0); prog[2] = ins(1, 1);  prog[3] = ins(3, 0);
    prog[4] = ins(1, 2);  prog[5] = ins(11, 0); prog[6] = ins(1, 5);  prog[7] = ins(4, 0);
    prog[8] = ins(1, 16); prog[9] = ins(11, 0); prog[10] = ins(9, 0); prog[11] = ins(15, 0);
    do_reset(); restart();
    repeat (4) step(0, 0);
    chk("add_y", acumulador, 0); chk("add_c", carry, 1); chk("add_z", zero, 1);
    repeat (4) step(0, 0);
    chk("sub_y", acumulador, 29); chk("sub_c", carry, 1); chk("sub_z", zero, 0);
    repeat (3) step(0, 0);
    chk("shl_y", acumulador, 0); chk("shl_c", carry, 1);
    step(0, 0);

    // OUT held 4 cycles by consumer, then IN with valid after 3 cycles
    load_nops();
    prog[0] = ins(1, 9); prog[1] = ins(11, 0); prog[2] = ins(12, 0);
    prog[3] = ins(2, 0); prog[4] = ins(15, 0);
    do_reset(); restart();
    repeat (2) step(0, 0);
    step(4, 0);
    chk("out_hold_saida", io.saida, 9);
    step(3, 19);
    chk("in_x_19", reg_x, 19);
    step(0, 0);

    // Countdown loop from Y=3
    load_nops();
    prog[0] = ins(1, 3); prog[1] = ins(11, 0); prog[2] = ins(1, 1); prog[3] = ins(4, 0);
    prog[4] = ins(14, 6); prog[5] = ins(13, 3); prog[6] = ins(15, 0);
    do_reset(); restart();
    for (int k = 0; k < 30 && !m_halt; k++) step(0, 0);
    chk("loop_halted", halted, 1);
    chk("loop_y", acumulador, 0);
    restart();
    chk("loop_y_kept", acumulador, 0);

    // pc wrap over 16 NOPs
    load_nops();
    do_reset(); restart();
    repeat (16) step(0, 0);
    chk("pc_wrap", pc, 0);

    // Reset while waiting on the output consumer
    load_nops();
    prog[0] = ins(1, 6); prog[1] = ins(11, 0); prog[2] = ins(12, 0);
    do_reset(); restart();
    repeat (2) step(0, 0);
    repeat (3) @(negedge clock);
    chk("pre_rst_state", estado, 5);
    chk("pre_rst_valid", io.saida_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", io.saida_valid, 0);
    chk("async_state", estado, 0);
    chk("async_pc", pc, 0);
    run = 1'b1;
    @(negedge clock);
    chk("run_in_reset", estado, 0);
    run = 1'b0;
    reset = 1'b0;
    model_clear();
    @(negedge clock);
    chk("post_rst_state", estado, 0);
    chk("post_rst_z", io.saida, 0);

    // Random programs
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < D; i++)
        prog[i] = ins($urandom_range(0, 15), $urandom_range(0, M - 1));
      do_reset(); restart();
      for (int k = 0; k < 40; k++)
        advance($urandom_range(0, 3), $urandom_range(0, M - 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
